// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, motion FSM states and floor-mask
// helpers used by elevator_motion_ctrl (and frequency_move users).
package elevator_pkg;

  localparam int unsigned FLOOR_COUNT = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR
  } state_e;

  // One-hot mask of a single floor.
  function automatic logic [FLOOR_COUNT-1:0] floor_onehot(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return '0;
    endcase
  endfunction

  // Mask of floors strictly above f.
  function automatic logic [FLOOR_COUNT-1:0] floors_above(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b110;
      2'd1:    return 3'b100;
      default: return '0;
    endcase
  endfunction

  // Mask of floors strictly below f.
  function automatic logic [FLOOR_COUNT-1:0] floors_below(input logic [1:0] f);
    case (f)
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/elevator_motion_ctrl_rise_detect.sv
// rise_detect: registered 1-bit rising-edge detector.
//   clk          in  system clock
//   button_reset in  asynchronous active-high reset
//   din          in  level input (same clock domain)
//   rise         out one-cycle pulse when din is 1 and was 0 last cycle
module rise_detect (
  input  logic clk,
  input  logic button_reset,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) din_q <= 1'b0;
    else              din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl: car-motion FSM for floors 0..2. Counts move_clk steps
// between floors, latches calls, runs the door timer, freezes under sos_mode.
//   clk, button_reset           clock, async active-high reset
//   move_clk                    travel step clock (rising edge = one step)
//   call_btn[2:0]               per-floor call requests
//   sos_mode                    freeze all state
//   weight_limit_exceeded       hold door open
//   led1..led3                  floor indicator, only while level at a floor
//   move_handler, door_open     motion / door status
//   floor_pos[1:0], dir_up      current or last-passed floor, last direction
//   pending[2:0]                latched unserved calls
module elevator_motion_ctrl #(
  parameter int unsigned STEPS_PER_FLOOR = 4,
  parameter int unsigned DOOR_CYCLES     = 50
) (
  input  logic       clk,
  input  logic       button_reset,
  input  logic       move_clk,
  input  logic [2:0] call_btn,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic       move_handler,
  output logic       door_open,
  output logic [1:0] floor_pos,
  output logic       dir_up,
  output logic [2:0] pending
);

  import elevator_pkg::*;

  localparam int unsigned SW = $clog2(STEPS_PER_FLOOR + 1);
  localparam int unsigned TW = $clog2(DOOR_CYCLES + 1);
  localparam logic [SW-1:0] SPF_L     = SW'(STEPS_PER_FLOOR);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES);

  state_e        state_q, state_d;
  logic [1:0]    floor_pos_q, floor_pos_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]    pending_q, pending_d;
  logic          dir_up_q, dir_up_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          step;
  logic [2:0]    here, req, latch, arrive_oh, further;
  logic [SW-1:0] cnt_inc;
  logic [1:0]    arrive_floor;

  // Detector keeps tracking move_clk during sos_mode, so a level held across
  // the freeze does not produce a spurious step on release.
  rise_detect u_step_detect (
    .clk          (clk),
    .button_reset (button_reset),
    .din          (move_clk),
    .rise         (step)
  );

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      state_q     <= S_IDLE;
      floor_pos_q <= 2'd0;
      step_cnt_q  <= '0;
      pending_q   <= '0;
      dir_up_q    <= 1'b1;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      floor_pos_q <= floor_pos_d;
      step_cnt_q  <= step_cnt_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    floor_pos_d  = floor_pos_q;
    step_cnt_d   = step_cnt_q;
    pending_d    = pending_q;
    dir_up_d     = dir_up_q;
    timer_d      = timer_q;
    here         = floor_onehot(floor_pos_q);
    req          = pending_q | call_btn;
    latch        = call_btn;
    cnt_inc      = step_cnt_q + SW'(1);
    arrive_floor = floor_pos_q;
    arrive_oh    = '0;
    further      = '0;

    if (!sos_mode) begin
      // While parked, a call at the current floor acts directly instead of latching.
      if (state_q == S_IDLE || state_q == S_DOOR) latch = call_btn & ~here;
      pending_d = pending_q | latch;

      unique case (state_q)
        S_IDLE: begin
          if (|(req & here)) begin
            state_d   = S_DOOR;
            timer_d   = DOOR_LOAD;
            pending_d = pending_d & ~here;
          end else if (dir_up_q && |(req & floors_above(floor_pos_q))) begin
            state_d = S_MOVE_UP;
          end else if (!dir_up_q && |(req & floors_below(floor_pos_q))) begin
            state_d = S_MOVE_DOWN;
          end else if (|(req & floors_above(floor_pos_q))) begin
            state_d  = S_MOVE_UP;
            dir_up_d = 1'b1;
          end else if (|(req & floors_below(floor_pos_q))) begin
            state_d  = S_MOVE_DOWN;
            dir_up_d = 1'b0;
          end
        end

        S_MOVE_UP, S_MOVE_DOWN: begin
          if (step) begin
            step_cnt_d = cnt_inc;
            if (cnt_inc == SPF_L) begin
              step_cnt_d   = '0;
              arrive_floor = (state_q == S_MOVE_UP) ? floor_pos_q + 2'd1 : floor_pos_q - 2'd1;
              floor_pos_d  = arrive_floor;
              arrive_oh    = floor_onehot(arrive_floor);
              further      = (state_q == S_MOVE_UP) ? floors_above(arrive_floor)
                                                    : floors_below(arrive_floor);
              if (|(pending_d & arrive_oh)) begin
                state_d   = S_DOOR;
                timer_d   = DOOR_LOAD;
                pending_d = pending_d & ~arrive_oh;
              end else if (!(|(pending_d & further))) begin
                state_d = S_IDLE;
              end
            end
          end
        end

        S_DOOR: begin
          if (weight_limit_exceeded || |(call_btn & here)) begin
            timer_d = DOOR_LOAD;
          end else begin
            timer_d = timer_q - TW'(1);
            if (timer_q == TW'(1)) state_d = S_IDLE;
          end
        end

        default: ;
      endcase
    end
  end

  logic [2:0] led_oh;
  assign led_oh       = here & {3{step_cnt_q == '0}};
  assign led1         = led_oh[0];
  assign led2         = led_oh[1];
  assign led3         = led_oh[2];
  assign move_handler = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
  assign door_open    = (state_q == S_DOOR);
  assign floor_pos    = floor_pos_q;
  assign dir_up       = dir_up_q;
  assign pending      = pending_q;

endmodule
